// File: rtl/j_pit_tick.sv
// j_pit_tick: programmable interval timer tick generator.
//   A prescaler down-counter feeds a divider down-counter. When both are at
//   zero on an enabled cycle the timer expires, and one cycle later the load
//   strobe/data pair for the downstream interrupt sync latch is presented.
//
// Ports:
//   sys_clk  in   clock, rising edge
//   reset    in   async active-high reset
//   clk_en   in   count qualifier
//   wr_pre   in   load prescaler reload/count from wdata
//   wr_div   in   load divider reload/count from wdata; nonzero starts the timer
//   wdata    in   write data [15:0]
//   irq_ack  in   CPU acknowledge pulse
//   irq_ld   out  latch load strobe
//   irq_d    out  latch data (1 = set, 0 = clear)
//   pre_cnt  out  live prescaler count (only with J_PIT_READBACK_EN)
//   div_cnt  out  live divider count   (only with J_PIT_READBACK_EN)
//
// Build option: define J_PIT_READBACK_EN to expose the counter registers.
//
// state   | meaning
// ST_IDLE | divider reload is zero; counters hold, no expiry
// ST_RUN  | counting on clk_en; expiry when both counters are zero

module j_pit_tick #(
  parameter int PRE_W = 16,
  parameter int DIV_W = 16
) (
  input  logic             sys_clk,
  input  logic             reset,
  input  logic             clk_en,
  input  logic             wr_pre,
  input  logic             wr_div,
  input  logic [15:0]      wdata,
  input  logic             irq_ack,
  output logic             irq_ld,
  output logic             irq_d
`ifdef J_PIT_READBACK_EN
  ,
  output logic [PRE_W-1:0] pre_cnt,
  output logic [DIV_W-1:0] div_cnt
`endif
);

  typedef enum logic {ST_IDLE = 1'b0, ST_RUN = 1'b1} state_t;

  localparam logic [PRE_W-1:0] PRE_ONE = PRE_W'(1);
  localparam logic [DIV_W-1:0] DIV_ONE = DIV_W'(1);

  state_t           state_q, state_d;
  logic [PRE_W-1:0] pre_rld_q, pre_rld_d;
  logic [PRE_W-1:0] pre_cnt_q, pre_cnt_d;
  logic [DIV_W-1:0] div_rld_q, div_rld_d;
  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic             irq_ld_q, irq_ld_d;
  logic             irq_d_q, irq_d_d;
  logic             expire;

  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      pre_rld_q <= '0;
      pre_cnt_q <= '0;
      div_rld_q <= '0;
      div_cnt_q <= '0;
      irq_ld_q  <= 1'b0;
      irq_d_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      pre_rld_q <= pre_rld_d;
      pre_cnt_q <= pre_cnt_d;
      div_rld_q <= div_rld_d;
      div_cnt_q <= div_cnt_d;
      irq_ld_q  <= irq_ld_d;
      irq_d_q   <= irq_d_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    pre_rld_d = pre_rld_q;
    pre_cnt_d = pre_cnt_q;
    div_rld_d = div_rld_q;
    div_cnt_d = div_cnt_q;
    expire    = 1'b0;

    if (wr_pre || wr_div) begin
      // A write takes the whole cycle: no counting, no expiry.
      if (wr_pre) begin
        pre_rld_d = wdata[PRE_W-1:0];
        pre_cnt_d = wdata[PRE_W-1:0];
      end
      if (wr_div) begin
        div_rld_d = wdata[DIV_W-1:0];
        div_cnt_d = wdata[DIV_W-1:0];
        state_d   = (wdata[DIV_W-1:0] != '0) ? ST_RUN : ST_IDLE;
      end
    end else if (state_q == ST_RUN && clk_en) begin
      if (pre_cnt_q != '0) begin
        pre_cnt_d = pre_cnt_q - PRE_ONE;
      end else begin
        pre_cnt_d = pre_rld_q;
        if (div_cnt_q != '0) begin
          div_cnt_d = div_cnt_q - DIV_ONE;
        end else begin
          div_cnt_d = div_rld_q;
          expire    = 1'b1;
        end
      end
    end
  end

  // Expiry outranks a coincident acknowledge; the ack is dropped.
  always_comb begin
    irq_ld_d = 1'b0;
    irq_d_d  = irq_d_q;
    if (expire) begin
      irq_ld_d = 1'b1;
      irq_d_d  = 1'b1;
    end else if (irq_ack) begin
      irq_ld_d = 1'b1;
      irq_d_d  = 1'b0;
    end
  end

  assign irq_ld = irq_ld_q;
  assign irq_d  = irq_d_q;

`ifdef J_PIT_READBACK_EN
  assign pre_cnt = pre_cnt_q;
  assign div_cnt = div_cnt_q;
`endif

endmodule

// File: tb/tb_j_pit_tick.sv
// Testbench for j_pit_tick. The reference model tracks the number of enabled
// cycles remaining until the next expiry and derives counter values from it.

module tb_j_pit_tick;

  logic        sys_clk;
  logic        reset;
  logic        clk_en;
  logic        wr_pre;
  logic        wr_div;
  logic [15:0] wdata;
  logic        irq_ack;
  logic        irq_ld;
  logic        irq_d;
`ifdef J_PIT_READBACK_EN
  logic [15:0] pre_cnt;
  logic [15:0] div_cnt;
`endif

  int total = 0;
  int bad   = 0;

  // model state
  longint m_prld, m_drld, m_rem;
  bit     m_run, m_ld, m_d;

  j_pit_tick dut (
    .sys_clk(sys_clk),
    .reset  (reset),
    .clk_en (clk_en),
    .wr_pre (wr_pre),
    .wr_div (wr_div),
    .wdata  (wdata),
    .irq_ack(irq_ack),
    .irq_ld (irq_ld),
    .irq_d  (irq_d)
`ifdef J_PIT_READBACK_EN
    ,
    .pre_cnt(pre_cnt),
    .div_cnt(div_cnt)
`endif
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  function automatic longint m_pcnt();
    return (m_rem - 1) % (m_prld + 1);
  endfunction

  function automatic longint m_dcnt();
    return (m_rem - 1) / (m_prld + 1);
  endfunction

  function automatic bit will_expire(bit en, bit wp, bit wd);
    return m_run && en && !wp && !wd && (m_rem == 1);
  endfunction

  task automatic model_reset();
    m_prld = 0; m_drld = 0; m_rem = 1;
    m_run = 0; m_ld = 0; m_d = 0;
  endtask

  // One clock cycle: drive inputs, advance DUT and model, return #1 after edge.
  task automatic step(input bit en, input bit wp, input bit wd,
                      input logic [15:0] dat, input bit ack);
    bit     exp;
    longint pc, dc, np, nprld, nd;
    clk_en  = en;
    wr_pre  = wp;
    wr_div  = wd;
    wdata   = dat;
    irq_ack = ack;
    exp = will_expire(en, wp, wd);
    @(posedge sys_clk);
    #1;
    if (wp || wd) begin
      pc    = m_pcnt();
      dc    = m_dcnt();
      np    = wp ? longint'(dat) : pc;
      nprld = wp ? longint'(dat) : m_prld;
      nd    = wd ? longint'(dat) : dc;
      m_rem = np + nd * (nprld + 1) + 1;
      m_prld = nprld;
      if (wd) begin
        m_drld = dat;
        m_run  = (dat != 0);
      end
    end else if (exp) begin
      m_rem = (m_prld + 1) * (m_drld + 1);
    end else if (m_run && en) begin
      m_rem = m_rem - 1;
    end
    if (exp) begin
      m_ld = 1; m_d = 1;
    end else if (ack) begin
      m_ld = 1; m_d = 0;
    end else begin
      m_ld = 0;
    end
    wr_pre  = 0;
    wr_div  = 0;
    irq_ack = 0;
  endtask

  task automatic test_reset();
    reset = 1; clk_en = 0; wr_pre = 0; wr_div = 0; wdata = 0; irq_ack = 0;
    model_reset();
    repeat (2) @(posedge sys_clk);
    #1;
    total++;
    if (irq_ld !== 1'b0 || irq_d !== 1'b0) begin
      bad++;
      $display("FAIL reset_outputs: irq_ld=%b irq_d=%b want 0 0", irq_ld, irq_d);
    end
`ifdef J_PIT_READBACK_EN
    total++;
    if (pre_cnt !== 16'd0 || div_cnt !== 16'd0) begin
      bad++;
      $display("FAIL reset_counts: pre=%0d div=%0d want 0 0", pre_cnt, div_cnt);
    end
`endif
    reset = 0;
    for (int k = 0; k < 10; k++) begin
      step(1, 0, 0, 0, 0);
      total++;
      if (irq_ld !== 1'b0) begin
        bad++;
        $display("FAIL reset_idle: step %0d irq_ld=%b want 0", k, irq_ld);
      end
    end
  endtask

  task automatic test_period();
    bit exp_ld;
    step(1, 1, 0, 16'd1, 0);
    step(1, 0, 1, 16'd2, 0);
    for (int k = 1; k <= 25; k++) begin
      step(1, 0, 0, 0, 0);
      exp_ld = (k % 6 == 0);
      total++;
      if (irq_ld !== exp_ld || (exp_ld && irq_d !== 1'b1)) begin
        bad++;
        $display("FAIL period6: step %0d irq_ld=%b irq_d=%b want ld=%b", k, irq_ld, irq_d, exp_ld);
      end
    end
  endtask

  task automatic test_idle_zero();
    step(1, 1, 0, 16'd0, 0);
    step(1, 0, 1, 16'd0, 0);
    step(1, 0, 1, 16'd0, 0);
    for (int k = 0; k < 20; k++) begin
      step(1, 0, 0, 0, 0);
      total++;
      if (irq_ld !== 1'b0) begin
        bad++;
        $display("FAIL idle_zero: step %0d irq_ld=%b want 0", k, irq_ld);
      end
    end
  endtask

  task automatic test_clk_en_toggle();
    int pulses[$];
    step(1, 1, 0, 16'd3, 0);
    step(1, 0, 1, 16'd1, 0);
    for (int k = 1; k <= 60; k++) begin
      step(k % 2 == 1, 0, 0, 0, 0);
      total++;
      if (irq_ld !== m_ld) begin
        bad++;
        $display("FAIL toggle_model: step %0d irq_ld=%b want %b", k, irq_ld, m_ld);
      end
      if (irq_ld === 1'b1) pulses.push_back(k);
    end
    total++;
    if (pulses.size() < 3) begin
      bad++;
      $display("FAIL toggle_count: pulses=%0d want >=3", pulses.size());
    end else begin
      for (int i = 1; i < pulses.size(); i++) begin
        total++;
        if (pulses[i] - pulses[i-1] != 16) begin
          bad++;
          $display("FAIL toggle_period: interval=%0d want 16", pulses[i] - pulses[i-1]);
        end
      end
    end
  endtask

  task automatic test_ack();
    int n;
    step(1, 1, 0, 16'd0, 0);
    step(1, 0, 1, 16'd2, 0);
    n = 0;
    while (!will_expire(1, 0, 0) && n < 100) begin
      step(1, 0, 0, 0, 0);
      n++;
    end
    total++;
    if (n >= 100) begin
      bad++;
      $display("FAIL ack_wait: no expiry within %0d cycles", n);
    end
    step(1, 0, 0, 0, 1);
    total++;
    if (irq_ld !== 1'b1 || irq_d !== 1'b1) begin
      bad++;
      $display("FAIL ack_on_expiry: irq_ld=%b irq_d=%b want 1 1", irq_ld, irq_d);
    end
    step(0, 0, 0, 0, 1);
    total++;
    if (irq_ld !== 1'b1 || irq_d !== 1'b0) begin
      bad++;
      $display("FAIL lone_ack: irq_ld=%b irq_d=%b want 1 0", irq_ld, irq_d);
    end
    step(0, 0, 0, 0, 0);
    total++;
    if (irq_ld !== 1'b0 || irq_d !== 1'b0) begin
      bad++;
      $display("FAIL ack_hold: irq_ld=%b irq_d=%b want 0 0", irq_ld, irq_d);
    end
  endtask

  task automatic test_write_on_expiry();
    int n;
    step(1, 1, 0, 16'd1, 0);
    step(1, 0, 1, 16'd2, 0);
    n = 0;
    while (!will_expire(1, 0, 0) && n < 100) begin
      step(1, 0, 0, 0, 0);
      n++;
    end
    step(1, 0, 1, 16'd5, 0);
    total++;
    if (irq_ld !== 1'b0) begin
      bad++;
      $display("FAIL wr_on_expiry: irq_ld=%b want 0", irq_ld);
    end
`ifdef J_PIT_READBACK_EN
    total++;
    if (div_cnt !== 16'd5 || pre_cnt !== 16'd0) begin
      bad++;
      $display("FAIL wr_on_expiry_cnt: pre=%0d div=%0d want 0 5", pre_cnt, div_cnt);
    end
`endif
    // divider restarts at 5 with prescale 2: next expiry 11 enabled cycles on
    for (int k = 1; k <= 12; k++) begin
      step(1, 0, 0, 0, 0);
      total++;
      if (irq_ld !== (k == 11)) begin
        bad++;
        $display("FAIL wr_on_expiry_next: step %0d irq_ld=%b want %b", k, irq_ld, (k == 11));
      end
    end
  endtask

  task automatic test_random();
    bit en, wp, wd, ack;
    logic [15:0] dat;
    step(1, 1, 0, 16'd1, 0);
    step(1, 0, 1, 16'd3, 0);
    for (int k = 0; k < 400; k++) begin
      en  = ($urandom % 4) != 0;
      wp  = ($urandom % 40) == 0;
      wd  = ($urandom % 40) == 0;
      ack = ($urandom % 8) == 0;
      dat = 16'($urandom_range(0, 4));
      if (wd && dat == 0 && ($urandom % 2) == 0) dat = 16'd2;
      step(en, wp, wd, dat, ack);
      total++;
      if (irq_ld !== m_ld || irq_d !== m_d) begin
        bad++;
        $display("FAIL random_irq: step %0d ld=%b d=%b want ld=%b d=%b", k, irq_ld, irq_d, m_ld, m_d);
      end
`ifdef J_PIT_READBACK_EN
      total++;
      if (longint'(pre_cnt) != m_pcnt() || longint'(div_cnt) != m_dcnt()) begin
        bad++;
        $display("FAIL random_cnt: step %0d pre=%0d div=%0d want %0d %0d", k, pre_cnt, div_cnt, m_pcnt(), m_dcnt());
      end
`endif
    end
  endtask

  task automatic test_reset_mid_run();
    int n;
    step(1, 1, 0, 16'd0, 0);
    step(1, 0, 1, 16'd3, 0);
    n = 0;
    while (m_d == 0 && n < 100) begin
      step(1, 0, 0, 0, 0);
      n++;
    end
    total++;
    if (irq_d !== 1'b1) begin
      bad++;
      $display("FAIL mid_run_setup: irq_d=%b want 1", irq_d);
    end
    #2;
    reset = 1;
    #1;
    total++;
    if (irq_ld !== 1'b0 || irq_d !== 1'b0) begin
      bad++;
      $display("FAIL mid_run_reset: irq_ld=%b irq_d=%b want 0 0", irq_ld, irq_d);
    end
`ifdef J_PIT_READBACK_EN
    total++;
    if (pre_cnt !== 16'd0 || div_cnt !== 16'd0) begin
      bad++;
      $display("FAIL mid_run_cnt: pre=%0d div=%0d want 0 0", pre_cnt, div_cnt);
    end
`endif
    model_reset();
    @(posedge sys_clk);
    #1;
    reset = 0;
    for (int k = 0; k < 20; k++) begin
      step(1, 0, 0, 0, (k == 5));
      total++;
      if (irq_ld !== (k == 5) || irq_d !== 1'b0) begin
        bad++;
        $display("FAIL post_reset: step %0d irq_ld=%b irq_d=%b want %b 0", k, irq_ld, irq_d, (k == 5));
      end
    end
  endtask

  initial begin
    test_reset();
    test_period();
    test_idle_zero();
    test_clk_en_toggle();
    test_ack();
    test_write_on_expiry();
    test_random();
    test_reset_mid_run();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
